// File: rtl/biquad_capture_sequencer.sv
// Programmable capture sequencer: pre-delay, ADC gate window, settle, then biquad reset.
// A capture_i rising edge starts a sequence. Zero-length phases are skipped.
module biquad_capture_sequencer #(
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                capture_i,
    input  logic                abort_i,
    input  logic                clear_i,
    input  logic [CNT_BITS-1:0] pre_delay_i,
    input  logic [CNT_BITS-1:0] gate_len_i,
    input  logic [CNT_BITS-1:0] settle_len_i,
    input  logic [CNT_BITS-1:0] reset_len_i,
    output logic                adc_gate_o,
    output logic                biquad_rst_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overrun_o
);

    localparam int unsigned N_PHASE = 4;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_GATE,
        S_SETTLE,
        S_RST
    } state_t;

    state_t              state;
    state_t              state_nxt;
    state_t              pick;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nxt;
    logic [CNT_BITS-1:0] pick_len;
    logic [CNT_BITS-1:0] len_in  [N_PHASE];
    logic [CNT_BITS-1:0] len_sh  [N_PHASE];
    logic [CNT_BITS-1:0] len_src [N_PHASE];
    logic [IDX_W-1:0]    start_idx;
    logic                capture_q;
    logic                cap_edge_c;
    logic                latch_c;
    logic                done_nxt;
    logic                overrun_nxt;

    function automatic state_t phase_state(input int idx);
        case (idx)
            0:       return S_PRE;
            1:       return S_GATE;
            2:       return S_SETTLE;
            default: return S_RST;
        endcase
    endfunction

    assign len_in[0]  = pre_delay_i;
    assign len_in[1]  = gate_len_i;
    assign len_in[2]  = settle_len_i;
    assign len_in[3]  = reset_len_i;
    assign cap_edge_c = capture_i & ~capture_q;

    // Next non-zero phase after the current one; IDLE reads live inputs, phases read the shadow copy.
    always_comb begin
        start_idx = '0;
        pick      = S_IDLE;
        pick_len  = '0;
        case (state)
            S_IDLE:   start_idx = IDX_W'(0);
            S_PRE:    start_idx = IDX_W'(1);
            S_GATE:   start_idx = IDX_W'(2);
            S_SETTLE: start_idx = IDX_W'(3);
            default:  start_idx = IDX_W'(4);
        endcase
        for (int i = 0; i < int'(N_PHASE); i++) begin
            len_src[i] = (state == S_IDLE) ? len_in[i] : len_sh[i];
        end
        for (int i = int'(N_PHASE) - 1; i >= 0; i--) begin
            if ((len_src[i] != '0) && (IDX_W'(i) >= start_idx)) begin
                pick     = phase_state(i);
                pick_len = len_src[i];
            end
        end
    end

    // Next-state, counter and flag logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        latch_c     = 1'b0;
        overrun_nxt = overrun_o;
        if (abort_i) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            if (clear_i) begin
                overrun_nxt = 1'b0;
            end
            if (state == S_IDLE) begin
                if (cap_edge_c) begin
                    latch_c   = 1'b1;
                    state_nxt = pick;
                    cnt_nxt   = (pick == S_IDLE) ? '0 : pick_len - CNT_BITS'(1);
                    done_nxt  = (pick == S_IDLE);
                end
            end else begin
                if (cap_edge_c) begin
                    overrun_nxt = 1'b1;
                end
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_BITS'(1);
                end else begin
                    state_nxt = pick;
                    cnt_nxt   = (pick == S_IDLE) ? '0 : pick_len - CNT_BITS'(1);
                    done_nxt  = (pick == S_IDLE);
                end
            end
        end
    end

    // State, shadow lengths and registered output decodes of the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            capture_q    <= 1'b1;
            adc_gate_o   <= 1'b0;
            biquad_rst_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            overrun_o    <= 1'b0;
            for (int i = 0; i < int'(N_PHASE); i++) begin
                len_sh[i] <= '0;
            end
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            capture_q    <= capture_i;
            adc_gate_o   <= (state_nxt == S_GATE);
            biquad_rst_o <= (state_nxt == S_RST);
            busy_o       <= (state_nxt != S_IDLE);
            done_o       <= done_nxt;
            overrun_o    <= overrun_nxt;
            if (latch_c) begin
                for (int i = 0; i < int'(N_PHASE); i++) begin
                    len_sh[i] <= len_in[i];
                end
            end
        end
    end

endmodule
